// File: rtl/fifo_stack_scheduler.sv
// rtl/fifo_stack_scheduler.sv - round-robin write arbiter and packet read scheduler in front of a FIFO stack
module fifo_stack_scheduler #(
  parameter int abits  = 4,
  parameter int dbits  = 2,
  parameter int rd_pkt = 4,
  parameter int nreq   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [nreq-1:0]           req_valid,
  input  logic [nreq*dbits-1:0]     req_data,
  output logic [nreq-1:0]           req_ready,
  output logic                      fifo_wr,
  output logic [dbits-1:0]          fifo_din,
  output logic                      fifo_rd,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  input  logic [dbits*rd_pkt-1:0]   fifo_dout,
  output logic                      pkt_valid,
  output logic [dbits*rd_pkt-1:0]   pkt_data,
  input  logic                      pkt_ready,
  output logic [abits:0]            level,
  output logic                      sync_err
);

  localparam int pw = (nreq > 1) ? $clog2(nreq) : 1;
  localparam logic [abits:0] depth     = (abits+1)'(1 << abits);
  localparam logic [abits:0] pkt_words = (abits+1)'(rd_pkt);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

  state_t        state;
  logic [pw-1:0] last;
  logic          rd_q;
  logic [pw-1:0] gidx;
  logic          gfound;
  logic          block;
  int            idx;

  // Search begins one past the last granted requester, wrapping around.
  always_comb begin
    gidx   = last;
    gfound = 1'b0;
    idx    = 0;
    for (int k = 1; k <= nreq; k++) begin
      idx = (int'(last) + k) % nreq;
      if (!gfound && req_valid[idx]) begin
        gfound = 1'b1;
        gidx   = pw'(idx);
      end
    end
  end

  assign block     = reset | fifo_full | (level == depth);
  assign req_ready = (gfound && !block) ? (nreq'(1) << gidx) : '0;
  assign fifo_wr   = |(req_valid & req_ready);
  assign fifo_din  = req_data[gidx*dbits +: dbits];
  assign fifo_rd   = rd_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= pw'(nreq - 1);
      rd_q      <= 1'b0;
      level     <= '0;
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
      sync_err  <= 1'b0;
    end else begin
      if (fifo_wr)
        last <= gidx;
      level <= level + {{abits{1'b0}}, fifo_wr} - (fifo_rd ? pkt_words : '0);
      if ((fifo_rd && fifo_empty) || (fifo_full && level < depth - 1'b1))
        sync_err <= 1'b1;
      case (state)
        IDLE: begin
          if (level >= pkt_words) begin
            state <= ISSUE;
            rd_q  <= 1'b1;
          end
        end
        ISSUE: begin
          rd_q  <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          pkt_data  <= fifo_dout;
          pkt_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (pkt_ready) begin
            pkt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stack_scheduler.sv
// tb/tb_fifo_stack_scheduler.sv - randomized and directed bench with a timeline model of the scheduler
module tb_fifo_stack_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [3:0] req_data;
  logic [1:0] req_ready;
  logic       fifo_wr;
  logic [1:0] fifo_din;
  logic       fifo_rd;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       pkt_ready;
  logic [4:0] level;
  logic       sync_err;

  fifo_stack_scheduler #(.abits(4), .dbits(2), .rd_pkt(4), .nreq(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_rd(fifo_rd),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_ready(pkt_ready),
    .level(level), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n = 0;

  bit         s_reset, s_pkt_ready, s_force_full, s_force_empty;
  logic [1:0] s_valid;
  logic [3:0] s_data;
  logic [7:0] s_dout;

  // Model: occupancy counter, last grant, and the cycle numbers of the pending read/capture.
  int         m_level, m_last, m_rd_at, m_cap_at;
  bit         m_busy, m_pv, m_err;
  logic [7:0] m_pdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_last = 1; m_rd_at = -1; m_cap_at = -1;
    m_busy = 0; m_pv = 0; m_err = 0; m_pdata = '0;
  endtask

  task automatic cycle();
    int g, idx;
    bit exp_rd, old_busy, old_pv;
    @(posedge clk); #1;
    reset      = s_reset;
    req_valid  = s_valid;
    req_data   = s_data;
    pkt_ready  = s_pkt_ready;
    fifo_dout  = s_dout;
    fifo_full  = s_force_full  | (m_level == 16);
    fifo_empty = s_force_empty | (m_level == 0);
    @(negedge clk);
    g = -1;
    if (!reset && !fifo_full && m_level < 16)
      for (int k = 1; k <= 2; k++) begin
        idx = (m_last + k) % 2;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    exp_rd = !reset && (n == m_rd_at);
    check("req_ready", 32'(req_ready), (g < 0) ? 0 : (1 << g));
    check("fifo_wr", 32'(fifo_wr), 32'(g >= 0));
    if (g >= 0) check("fifo_din", 32'(fifo_din), 32'(req_data[g*2 +: 2]));
    check("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
    check("level", 32'(level), 32'(m_level));
    check("pkt_valid", 32'(pkt_valid), 32'(m_pv));
    check("pkt_data", 32'(pkt_data), 32'(m_pdata));
    check("sync_err", 32'(sync_err), 32'(m_err));
    if (reset) begin
      model_reset();
    end else begin
      if ((exp_rd && fifo_empty) || (fifo_full && m_level < 15)) m_err = 1;
      old_busy = m_busy;
      old_pv   = m_pv;
      if (old_pv && pkt_ready) begin m_pv = 0; m_busy = 0; end
      if (n == m_cap_at) begin m_pv = 1; m_pdata = fifo_dout; end
      if (!old_busy && m_level >= 4) begin m_busy = 1; m_rd_at = n + 1; m_cap_at = n + 2; end
      if (g >= 0) m_last = g;
      m_level = m_level + ((g >= 0) ? 1 : 0) - (exp_rd ? 4 : 0);
    end
    n++;
  endtask

  task automatic idle_stim();
    s_reset = 0; s_valid = 0; s_data = 0; s_pkt_ready = 1;
    s_dout = 8'hA5; s_force_full = 0; s_force_empty = 0;
  endtask

  task automatic do_reset(input int cycles);
    idle_stim();
    s_reset = 1;
    for (int i = 0; i < cycles; i++) begin
      cycle();
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_fifo_rd", 32'(fifo_rd), 0);
      check("rst_fifo_wr", 32'(fifo_wr), 0);
    end
    s_reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish at cycle %0d", n);
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] dseq [4];
    int wr_count;
    dseq = '{2'd1, 2'd2, 2'd3, 2'd2};
    reset = 1; req_valid = 0; req_data = 0; pkt_ready = 1;
    fifo_dout = 0; fifo_full = 0; fifo_empty = 1;
    model_reset();
    @(posedge clk);

    // Reset, then four words from requester 0 and one packet out.
    do_reset(2);
    check("reset_level", 32'(level), 0);
    check("reset_pkt_valid", 32'(pkt_valid), 0);
    for (int i = 0; i < 4; i++) begin
      s_valid = 2'b01; s_data = {2'b00, dseq[i]};
      cycle();
      check("w_fifo_wr", 32'(fifo_wr), 1);
      check("w_fifo_din", 32'(fifo_din), 32'(dseq[i]));
    end
    s_valid = 0;
    cycle();
    check("lvl4", 32'(level), 4);
    check("lvl4_no_rd", 32'(fifo_rd), 0);
    cycle();
    check("issue_rd", 32'(fifo_rd), 1);
    cycle();
    check("capture_pv", 32'(pkt_valid), 0);
    check("capture_level", 32'(level), 0);
    cycle();
    check("pkt_valid_lat", 32'(pkt_valid), 1);
    check("pkt_data_lit", 32'(pkt_data), 32'hA5);

    // Alternating grants.
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      s_valid = 2'b11; s_data = 4'b1001;
      cycle();
      check("rr_seq", 32'(req_ready), (i % 2 == 0) ? 1 : 2);
    end

    // Downstream stalled: fill to 16, then reset out of HOLD.
    do_reset(1);
    s_pkt_ready = 0; s_valid = 2'b01; s_data = 4'b0011;
    wr_count = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (fifo_wr) wr_count++;
    end
    check("stall_writes", 32'(wr_count), 20);
    check("stall_level", 32'(level), 16);
    check("stall_ready", 32'(req_ready), 0);
    check("stall_wr", 32'(fifo_wr), 0);
    check("stall_pv", 32'(pkt_valid), 1);
    do_reset(1);
    s_valid = 2'b11;
    cycle();
    check("hold_rst_pv", 32'(pkt_valid), 0);
    check("hold_rst_level", 32'(level), 0);
    check("hold_rst_grant", 32'(req_ready), 1);

    // Write coincident with the pop at level 5.
    do_reset(1);
    s_valid = 2'b01;
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (i == 5) begin
        check("co_rd", 32'(fifo_rd), 1);
        check("co_wr", 32'(fifo_wr), 1);
        check("co_level5", 32'(level), 5);
      end
      if (i == 6) check("co_level2", 32'(level), 2);
    end

    // sync_err from a pop while empty, then from an early full.
    do_reset(1);
    s_valid = 2'b01;
    for (int i = 0; i < 4; i++) cycle();
    s_valid = 0;
    cycle();
    s_force_empty = 1;
    cycle();
    check("empty_rd", 32'(fifo_rd), 1);
    s_force_empty = 0;
    cycle();
    check("err_empty", 32'(sync_err), 1);
    do_reset(1);
    s_force_full = 1;
    cycle();
    check("err_pre", 32'(sync_err), 0);
    s_force_full = 0;
    cycle();
    check("err_full", 32'(sync_err), 1);
    cycle();
    check("err_sticky", 32'(sync_err), 1);

    // Random traffic.
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      s_reset       = ($urandom_range(0, 299) == 0);
      s_valid       = 2'($urandom_range(0, 3));
      s_data        = 4'($urandom);
      s_pkt_ready   = ($urandom_range(0, 3) != 0);
      s_dout        = 8'($urandom);
      s_force_full  = ($urandom_range(0, 399) == 0);
      s_force_empty = ($urandom_range(0, 399) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_stack_scheduler.md
FIFO_STACK_SCHEDULER -- requirements
Module: fifo_stack_scheduler

Parameters
REQ-001 SHALL provide parameters: abits, default 4, FIFO depth is 2**abits words; dbits, default 2, word width; rd_pkt, default 4, words popped per read; nreq, default 2, number of write requesters (range 2..4).

Interface
REQ-002 SHALL provide clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL provide reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL provide req_valid, input, nreq bits: per-requester write request.
REQ-005 SHALL provide req_data, input, nreq*dbits bits: requester i occupies slice [i*dbits +: dbits].
REQ-006 SHALL provide req_ready, output, nreq bits: one-hot grant; a word transfers when valid and ready are both high.
REQ-007 SHALL provide fifo_wr, output, 1 bit and fifo_din, output, dbits bits: push to the FIFO stack.
REQ-008 SHALL provide fifo_rd, output, 1 bit: pops rd_pkt words; fifo_dout is valid the following cycle.
REQ-009 SHALL provide fifo_full and fifo_empty, inputs, 1 bit each; and fifo_dout, input, dbits*rd_pkt bits.
REQ-010 SHALL provide pkt_valid, output, 1 bit; pkt_data, output, dbits*rd_pkt bits; and pkt_ready, input, 1 bit: downstream packet handshake.
REQ-011 SHALL provide level, output, abits+1 bits: scheduler-tracked FIFO occupancy in words.
REQ-012 SHALL provide sync_err, output, 1 bit: sticky FIFO/level mismatch flag.

Function
REQ-013 Write arbitration SHALL be combinational round-robin over req_valid, with at most one req_ready bit high per cycle.
REQ-014 Search SHALL start at the requester after the last granted one; the pointer updates only on a completed transfer.
REQ-015 Grant SHALL be suppressed (req_ready all 0) when fifo_full=1 or level == 2**abits.
REQ-016 fifo_wr SHALL equal |(req_valid & req_ready), and fifo_din SHALL be the granted requester's slice; fifo_din is don't-care when fifo_wr=0.
REQ-017 level SHALL update as level + fifo_wr - (fifo_rd ? rd_pkt : 0) each cycle; a simultaneous write and read SHALL apply both.
REQ-018 The read FSM SHALL have states IDLE, ISSUE, CAPTURE and HOLD.
REQ-019 IDLE -> ISSUE when level >= rd_pkt (registered value); otherwise stay in IDLE.
REQ-020 ISSUE SHALL assert fifo_rd for exactly one cycle, then move to CAPTURE.
REQ-021 CAPTURE SHALL register fifo_dout into pkt_data, set pkt_valid=1 next cycle, and move to HOLD.
REQ-022 HOLD SHALL keep pkt_valid and pkt_data stable until pkt_ready=1; on that edge it clears pkt_valid and returns to IDLE.
REQ-023 Read-to-packet latency from the ISSUE cycle to pkt_valid=1 SHALL be 2 cycles.
REQ-024 No new fifo_rd SHALL be issued while the FSM is in CAPTURE or HOLD; writes continue during those states.
REQ-025 sync_err SHALL set if fifo_rd=1 while fifo_empty=1, or if fifo_full=1 while level < 2**abits - 1; it clears only on reset.

Reset
REQ-026 While reset=1 at a clock edge, the block SHALL enter IDLE, set level=0, and set the round-robin pointer so requester 0 has top priority.
REQ-027 While reset=1 at a clock edge, the block SHALL also clear pkt_valid=0, pkt_data=0 and sync_err=0.
REQ-028 During reset, req_ready, fifo_wr and fifo_rd SHALL be 0.
REQ-029 Reset SHALL take priority over any in-flight packet, which is discarded.

Verification
REQ-030 Reset for 2 cycles -> all outputs 0, level=0.
REQ-031 Requester 0 only, 4 words (din 1,2,3,2) -> 4 fifo_wr cycles, level=4, fifo_rd one cycle later, pkt_valid 2 cycles after fifo_rd, pkt_data=fifo_dout, level=0.
REQ-032 Both requesters valid continuously -> req_ready sequence 01,10,01,10 (req0 first).
REQ-033 pkt_ready=0 with continuous writes -> one packet popped at level 4, then FSM held in HOLD; after 20 writes level=16, req_ready=0, fifo_wr=0.
REQ-034 level=5, write coincident with fifo_rd -> level=2 next cycle.
REQ-035 reset asserted in HOLD -> next cycle pkt_valid=0, level=0, state IDLE, next grant goes to requester 0.
